// File: rtl/snoop_pkg.sv
// rtl/snoop_pkg.sv - shared types for the snoop statistics controller
package snoop_pkg;

    localparam int SNOOP_LEN_WIDTH = 16;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        SYNC   = 2'd1,
        IDLE   = 2'd2,
        IN_PKT = 2'd3
    } snoop_state_e;

    typedef struct packed {
        logic                       trunc;
        logic [SNOOP_LEN_WIDTH-1:0] flits;
        logic [SNOOP_LEN_WIDTH-1:0] len;
    } snoop_rec_t;

endpackage

// File: rtl/keep_popcount.sv
// rtl/keep_popcount.sv - tkeep byte count with its registered beat stage
module keep_popcount #(
    parameter int TKEEP_WIDTH = 64,
    parameter int CW          = $clog2(TKEEP_WIDTH + 1)
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic                   in_valid,
    input  logic                   in_last,
    input  logic [TKEEP_WIDTH-1:0] keep,
    output logic                   out_valid,
    output logic                   out_last,
    output logic [CW-1:0]          out_count
);

    logic [CW-1:0] cnt;

    // Count every set keep bit; sparse keep patterns are counted as-is.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < TKEEP_WIDTH; i++) begin
            cnt = cnt + CW'(keep[i]);
        end
    end

    // Stage-1 register: one counted beat with its byte count and last flag.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_count <= '0;
        end else begin
            out_valid <= in_valid;
            out_last  <= in_valid & in_last;
            out_count <= in_valid ? cnt : '0;
        end
    end

endmodule

// File: rtl/snoop_rec_fifo.sv
// rtl/snoop_rec_fifo.sv - small record queue, caller guards write/read legality
module snoop_rec_fifo #(
    parameter int DW    = 33,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          aresetn,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; the extra MSB separates full from empty.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset because empty gates the head.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/snoop_stats_ctrl.sv
// rtl/snoop_stats_ctrl.sv - passive per-packet length statistics on a monitored stream
module snoop_stats_ctrl
    import snoop_pkg::*;
#(
    parameter int TDATA_WIDTH = 512,
    parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
    parameter int LEN_WIDTH   = SNOOP_LEN_WIDTH,
    parameter int CNT_WIDTH   = 32,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic                   mon_tvalid,
    input  logic                   mon_tready,
    input  logic                   mon_tlast,
    input  logic [TKEEP_WIDTH-1:0] mon_tkeep,
    input  logic                   enable,
    input  logic                   clear,
    output logic                   rec_valid,
    input  logic                   rec_ready,
    output logic [LEN_WIDTH-1:0]   rec_len,
    output logic [LEN_WIDTH-1:0]   rec_flits,
    output logic                   rec_trunc,
    output logic [CNT_WIDTH-1:0]   pkt_count,
    output logic [CNT_WIDTH-1:0]   byte_count,
    output logic [CNT_WIDTH-1:0]   drop_count,
    output logic                   busy
);

    localparam int PCW = $clog2(TKEEP_WIDTH + 1);
    localparam int RW  = 2 * LEN_WIDTH + 1;
    localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;

    snoop_state_e state, state_nxt;

    logic                 beat;
    logic                 counted;
    logic                 s1_valid;
    logic                 s1_last;
    logic [PCW-1:0]       s1_count;

    logic [LEN_WIDTH-1:0] acc_len;
    logic [LEN_WIDTH-1:0] acc_flits;
    logic                 acc_trunc;
    logic [CNT_WIDTH-1:0] acc_bytes;

    logic [LEN_WIDTH:0]   len_sum;
    logic [LEN_WIDTH:0]   flits_sum;
    logic [LEN_WIDTH-1:0] len_new;
    logic [LEN_WIDTH-1:0] flits_new;
    logic                 trunc_new;
    logic [CNT_WIDTH-1:0] bytes_new;

    logic                 rec_wr;
    logic                 rec_rd;
    logic                 fifo_wr;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 drop;
    logic [RW-1:0]        head;

    assign beat = mon_tvalid & mon_tready;

    // State register.
    always_ff @(posedge clk) begin
        if (!aresetn) state <= OFF;
        else          state <= state_nxt;
    end

    // Next state: SYNC skips to the first packet boundary; an open packet always finishes.
    always_comb begin
        state_nxt = state;
        case (state)
            OFF:    if (enable) state_nxt = SYNC;
            SYNC:   if (!enable) state_nxt = OFF;
                    else if (beat && mon_tlast) state_nxt = IDLE;
            IDLE:   if (!enable) state_nxt = OFF;
                    else if (beat && !mon_tlast) state_nxt = IN_PKT;
            IN_PKT: if (beat && mon_tlast) state_nxt = enable ? IDLE : OFF;
            default: state_nxt = OFF;
        endcase
    end

    // Outputs of the FSM: which beats belong to a recorded packet.
    always_comb begin
        busy    = (state == IN_PKT);
        counted = beat && (((state == IDLE) && enable) || (state == IN_PKT));
    end

    keep_popcount #(
        .TKEEP_WIDTH (TKEEP_WIDTH),
        .CW          (PCW)
    ) u_pop (
        .clk       (clk),
        .aresetn   (aresetn),
        .in_valid  (counted),
        .in_last   (mon_tlast),
        .keep      (mon_tkeep),
        .out_valid (s1_valid),
        .out_last  (s1_last),
        .out_count (s1_count)
    );

    // Saturating per-packet sums including the beat in stage 1.
    always_comb begin
        len_sum   = {1'b0, acc_len} + (LEN_WIDTH+1)'(s1_count);
        flits_sum = {1'b0, acc_flits} + (LEN_WIDTH+1)'(1);
        len_new   = len_sum[LEN_WIDTH]   ? LEN_MAX : len_sum[LEN_WIDTH-1:0];
        flits_new = flits_sum[LEN_WIDTH] ? LEN_MAX : flits_sum[LEN_WIDTH-1:0];
        trunc_new = acc_trunc | len_sum[LEN_WIDTH] | flits_sum[LEN_WIDTH];
        bytes_new = acc_bytes + CNT_WIDTH'(s1_count);
    end

    assign rec_wr  = s1_valid & s1_last;
    assign rec_rd  = rec_valid & rec_ready;
    assign fifo_wr = rec_wr & (~fifo_full | rec_rd);
    assign drop    = rec_wr & fifo_full & ~rec_rd;

    // Packet accumulators; restart from zero once the record is formed.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            acc_len   <= '0;
            acc_flits <= '0;
            acc_trunc <= 1'b0;
            acc_bytes <= '0;
        end else if (s1_valid) begin
            if (s1_last) begin
                acc_len   <= '0;
                acc_flits <= '0;
                acc_trunc <= 1'b0;
                acc_bytes <= '0;
            end else begin
                acc_len   <= len_new;
                acc_flits <= flits_new;
                acc_trunc <= trunc_new;
                acc_bytes <= bytes_new;
            end
        end
    end

    // Running totals; clear overrides any increment in the same cycle.
    always_ff @(posedge clk) begin
        if (!aresetn || clear) begin
            pkt_count  <= '0;
            byte_count <= '0;
            drop_count <= '0;
        end else if (rec_wr) begin
            pkt_count  <= pkt_count + CNT_WIDTH'(1);
            byte_count <= byte_count + bytes_new;
            if (drop && (drop_count != '1)) drop_count <= drop_count + CNT_WIDTH'(1);
        end
    end

    snoop_rec_fifo #(
        .DW    (RW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .aresetn (aresetn),
        .wr_en   (fifo_wr),
        .wr_data ({trunc_new, flits_new, len_new}),
        .rd_en   (rec_rd),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Head of queue, forced to zero when nothing is held.
    always_comb begin
        rec_valid = ~fifo_empty;
        rec_trunc = rec_valid & head[RW-1];
        rec_flits = rec_valid ? head[2*LEN_WIDTH-1:LEN_WIDTH] : '0;
        rec_len   = rec_valid ? head[LEN_WIDTH-1:0] : '0;
    end

endmodule

// File: tb/tb_snoop_stats_ctrl.sv
// tb/tb_snoop_stats_ctrl.sv - self-checking bench for snoop_stats_ctrl
module tb_snoop_stats_ctrl;
    import snoop_pkg::*;

    localparam int KW = 64;
    localparam logic [KW-1:0] FULL = '1;
    localparam int M_OFF = 0, M_SYNC = 1, M_IDLE = 2, M_IN = 3;

    bit clk;
    logic aresetn, mon_tvalid, mon_tready, mon_tlast, enable, clear, rec_ready;
    logic [KW-1:0] mon_tkeep;
    logic rec_valid, rec_trunc, busy;
    logic [15:0] rec_len, rec_flits;
    logic [31:0] pkt_count, byte_count, drop_count;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 0;

    snoop_stats_ctrl dut (
        .clk(clk), .aresetn(aresetn), .mon_tvalid(mon_tvalid), .mon_tready(mon_tready),
        .mon_tlast(mon_tlast), .mon_tkeep(mon_tkeep), .enable(enable), .clear(clear),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_len(rec_len), .rec_flits(rec_flits),
        .rec_trunc(rec_trunc), .pkt_count(pkt_count), .byte_count(byte_count),
        .drop_count(drop_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    snoop_rec_t   mq[$];
    int           mst;
    longint       pbytes, pflits;
    bit           pend;
    snoop_rec_t   pend_rec;
    longint       pend_bytes;
    logic [31:0]  m_pkt, m_byte, m_drop;

    always @(posedge clk) begin
        if (!aresetn) begin
            mq.delete();
            mst = M_OFF; pbytes = 0; pflits = 0; pend = 0;
            m_pkt = 0; m_byte = 0; m_drop = 0;
        end else begin
            bit do_pop, can, b, take;
            do_pop = (mq.size() > 0) && rec_ready;
            can    = (mq.size() < 4) || do_pop;
            if (do_pop) void'(mq.pop_front());
            if (pend && can) mq.push_back(pend_rec);
            if (clear) begin
                m_pkt = 0; m_byte = 0; m_drop = 0;
            end else if (pend) begin
                m_pkt  = m_pkt + 1;
                m_byte = m_byte + pend_bytes[31:0];
                if (!can && m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 1;
            end
            pend = 0;
            b    = mon_tvalid && mon_tready;
            take = 0;
            case (mst)
                M_OFF:  if (enable) mst = M_SYNC;
                M_SYNC: if (!enable) mst = M_OFF; else if (b && mon_tlast) mst = M_IDLE;
                M_IDLE: if (!enable) mst = M_OFF;
                        else if (b) begin take = 1; if (!mon_tlast) mst = M_IN; end
                default: if (b) begin take = 1; if (mon_tlast) mst = enable ? M_IDLE : M_OFF; end
            endcase
            if (take) begin
                pbytes += $countones(mon_tkeep);
                pflits += 1;
                if (mon_tlast) begin
                    pend           = 1;
                    pend_rec.trunc = (pbytes > 65535) || (pflits > 65535);
                    pend_rec.len   = (pbytes > 65535) ? 16'hFFFF : pbytes[15:0];
                    pend_rec.flits = (pflits > 65535) ? 16'hFFFF : pflits[15:0];
                    pend_bytes     = pbytes;
                    pbytes = 0; pflits = 0;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("rec_valid", rec_valid, mq.size() > 0);
            if (mq.size() > 0) begin
                chk("rec_len", rec_len, mq[0].len);
                chk("rec_flits", rec_flits, mq[0].flits);
                chk("rec_trunc", rec_trunc, mq[0].trunc);
            end
            chk("pkt_count", pkt_count, m_pkt);
            chk("byte_count", byte_count, m_byte);
            chk("drop_count", drop_count, m_drop);
            chk("busy", busy, mst == M_IN);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive_beat(input logic [KW-1:0] k, input logic l);
        mon_tvalid = 1; mon_tready = 1; mon_tkeep = k; mon_tlast = l;
        @(negedge clk);
        mon_tvalid = 0; mon_tlast = 0; mon_tkeep = '0;
    endtask

    task automatic drive_stall(input logic [KW-1:0] k);
        mon_tvalid = 1; mon_tready = 0; mon_tkeep = k; mon_tlast = 1;
        @(negedge clk);
        mon_tvalid = 0; mon_tready = 1; mon_tlast = 0; mon_tkeep = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clear();
        clear = 1;
        @(negedge clk);
        clear = 0;
    endtask

    initial begin
        int pops;
        aresetn = 0; enable = 0; clear = 0; rec_ready = 1;
        mon_tvalid = 0; mon_tready = 1; mon_tlast = 0; mon_tkeep = '0;
        @(negedge clk);
        chk_on = 1;
        idle(2);
        chk("reset rec_valid", rec_valid, 0);
        chk("reset pkt_count", pkt_count, 0);
        chk("reset busy", busy, 0);

        // 1: join mid-packet, first packet skipped, then 64+64+4 bytes
        aresetn = 1; enable = 1;
        idle(1);
        drive_beat(FULL, 0);
        drive_beat(FULL, 1);
        drive_beat(FULL, 0);
        drive_stall(FULL);
        drive_beat(FULL, 0);
        drive_beat(64'hF, 1);
        chk("t1 latency N+1", rec_valid, 0);
        idle(1);
        chk("t1 rec_valid N+2", rec_valid, 1);
        chk("t1 len", rec_len, 132);
        chk("t1 flits", rec_flits, 3);
        idle(2);

        // 2: zero-byte single beat packet
        pulse_clear();
        drive_beat('0, 1);
        idle(1);
        chk("t2 len", rec_len, 0);
        chk("t2 flits", rec_flits, 1);
        chk("t2 trunc", rec_trunc, 0);
        chk("t2 pkt_count", pkt_count, 1);
        idle(3);

        // 3: consumer stalled, FIFO fills and drops
        pulse_clear();
        rec_ready = 0;
        repeat (6) drive_beat(64'h1, 1);
        idle(3);
        chk("t3 drop_count", drop_count, 2);
        chk("t3 pkt_count", pkt_count, 6);
        chk("t3 head len", rec_len, 1);
        rec_ready = 1;
        pops = 0;
        for (int i = 0; i < 8; i++) begin
            if (rec_valid) pops++;
            @(negedge clk);
        end
        chk("t3 pops", pops, 4);

        // 4: long packet saturates length
        pulse_clear();
        for (int i = 0; i < 1100; i++) drive_beat(FULL, i == 1099);
        idle(1);
        chk("t4 len", rec_len, 65535);
        chk("t4 flits", rec_flits, 1100);
        chk("t4 trunc", rec_trunc, 1);
        chk("t4 byte_count", byte_count, 70400);
        idle(2);

        // 5: enable drops mid-packet, packet still completes; re-enable mid-packet
        pulse_clear();
        drive_beat(FULL, 0);
        enable = 0;
        drive_beat(64'hFF, 0);
        drive_beat(64'h1, 1);
        idle(1);
        chk("t5 len", rec_len, 73);
        drive_beat(FULL, 1);
        drive_beat(FULL, 1);
        idle(3);
        chk("t5 ignored pkt_count", pkt_count, 1);
        enable = 1;
        drive_beat(FULL, 0);
        drive_beat(FULL, 0);
        drive_beat(FULL, 1);
        drive_beat(64'hFF, 0);
        drive_stall(FULL);
        drive_beat(64'hFF, 1);
        idle(1);
        chk("t5 rearm len", rec_len, 16);
        chk("t5 rearm pkt_count", pkt_count, 2);
        idle(2);

        // 6: reset mid-packet, then clear racing a record write
        drive_beat(FULL, 0);
        drive_beat(FULL, 0);
        chk("t6 busy before reset", busy, 1);
        aresetn = 0;
        idle(1);
        chk("t6 reset busy", busy, 0);
        chk("t6 reset pkt_count", pkt_count, 0);
        chk("t6 reset byte_count", byte_count, 0);
        chk("t6 reset rec_valid", rec_valid, 0);
        aresetn = 1;
        idle(1);
        drive_beat(FULL, 0);
        drive_beat(FULL, 1);
        drive_beat(64'h3, 1);
        pulse_clear();
        chk("t6 clear pkt_count", pkt_count, 0);
        chk("t6 clear byte_count", byte_count, 0);
        chk("t6 record kept", rec_valid, 1);
        chk("t6 record len", rec_len, 2);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
